// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory port plus the decode handshake.
// A decode transfer happens on every rising edge where dec_valid && dec_ready; dec_valid never waits
// on dec_ready, and the head stays stable while dec_valid && !dec_ready unless the fetch unit is redirected.
interface ifetch_ctrl_if;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rd;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  modport master (
    output imem_addr, imem_en, dec_valid, dec_instr, dec_pc,
    input  imem_rd, dec_ready
  );

  modport slave (
    input  imem_addr, imem_en, dec_valid, dec_instr, dec_pc,
    output imem_rd, dec_ready
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational imem, buffers {pc, instr} in a
// small FIFO toward decode, flushes on redirect and stops fetching after an EBREAK is enqueued.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  ifetch_ctrl_if.master     bus,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [1:0]        state_dbg
);

  localparam int          AW       = $clog2(QDEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] pc;
  logic [31:0] q_instr [QDEPTH];
  logic [31:0] q_pc    [QDEPTH];
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;
  logic [AW:0] occupancy;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic is_ebreak;
  logic flush;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign occupancy = wr_ptr - rd_ptr;
  assign rd_idx    = rd_ptr[AW-1:0];
  assign wr_idx    = wr_ptr[AW-1:0];
  assign empty     = (occupancy == '0);
  assign full      = (occupancy == FULL_CNT);
  assign is_ebreak = (bus.imem_rd == EBREAK);
  assign flush     = redirect_valid;
  assign pop       = bus.dec_valid && bus.dec_ready;

  assign bus.imem_addr = pc;
  assign bus.dec_valid = !empty;
  assign bus.dec_instr = empty ? 32'h0 : q_instr[rd_idx];
  assign bus.dec_pc    = empty ? 32'h0 : q_pc[rd_idx];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_RUN;
      S_RUN:    if (push && is_ebreak) state_nxt = S_HALTED;
      S_HALTED: if (redirect_valid) state_nxt = S_RUN;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A full FIFO still accepts a fetch when decode drains the head in the same cycle.
  always_comb begin
    push        = (state == S_RUN) && !redirect_valid && (!full || pop);
    bus.imem_en = push;
    halted      = (state == S_HALTED);
    state_dbg   = state;
  end

  // ---------------- PC ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (push && !is_ebreak) begin
      pc <= pc + 32'd4;
    end
  end

  // ---------------- FIFO pointers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // ---------------- FIFO storage ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= 32'h0;
        q_pc[i]    <= 32'h0;
      end
    end else if (push) begin
      q_instr[wr_idx] <= bus.imem_rd;
      q_pc[wr_idx]    <= pc;
    end
  end

  // ---------------- Handshake counter ----------------
  // A pop coinciding with a redirect belongs to a squashed stream and is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (pop && !redirect_valid) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  // ---------------- Invariants ----------------
  a_en_only_run: assert property (@(posedge clk) disable iff (reset)
    bus.imem_en |-> (state == S_RUN));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(full && push && !pop));
  a_halt_no_fetch: assert property (@(posedge clk) disable iff (reset)
    halted |-> !bus.imem_en);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: table-driven directed vectors, hand-written corner sequences, and a
// randomized run checked against a queue-based fetch model.
module tb_ifetch_ctrl;

  localparam int          QDEPTH = 2;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [31:0] fetch_count;
  logic [1:0]  state_dbg;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  ifetch_ctrl_if bus();
  assign bus.imem_rd = mem[bus.imem_addr[9:2]];

  ifetch_ctrl #(.RESET_PC(32'h0), .QDEPTH(QDEPTH), .CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .state_dbg      (state_dbg)
  );

  // ---------------- checks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    start          = st;
    bus.dec_ready  = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    start          = 1'b0;
    bus.dec_ready  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0020_81B3;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        st;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_en;
    logic [31:0] e_addr;
    logic [31:0] e_fc;
  } vec_t;

  vec_t vecs [17];

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_HALT} mmode_t;
  mmode_t      m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_fc;
  logic [63:0] mq[$];

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    bus.dec_ready  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    fill_mem();

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h00, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h00, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  1'b1, 32'h04, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1'b1, 32'h08, 32'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  1'b1, 32'h0C, 32'd2};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  1'b1, 32'h10, 32'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'h14, 32'd4};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'h18, 32'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'h18, 32'd4};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'h18, 32'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'h18, 32'd4};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'h18, 32'd4};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1, 32'h1C, 32'd5};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h43, 1'b1, 32'h18, 1'b0, 32'h20, 32'd6};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h40, 32'd6};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 1'b1, 32'h44, 32'd6};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 32'h48, 32'd7};

    // Reset values
    do_reset();
    #1;
    chk1("rst_dec_valid", bus.dec_valid, 1'b0);
    chk ("rst_dec_instr", bus.dec_instr, 32'h0);
    chk ("rst_dec_pc",    bus.dec_pc,    32'h0);
    chk1("rst_imem_en",   bus.imem_en,   1'b0);
    chk ("rst_imem_addr", bus.imem_addr, 32'h0);
    chk1("rst_halted",    halted,        1'b0);
    chk ("rst_fcount",    fetch_count,   32'h0);

    // Stream, back-pressure, and redirect while full
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].st, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      chk1($sformatf("vec%0d_valid", i), bus.dec_valid, vecs[i].e_valid);
      chk1($sformatf("vec%0d_en", i),    bus.imem_en,   vecs[i].e_en);
      chk ($sformatf("vec%0d_addr", i),  bus.imem_addr, vecs[i].e_addr);
      chk ($sformatf("vec%0d_fc", i),    fetch_count,   vecs[i].e_fc);
      chk1($sformatf("vec%0d_halt", i),  halted,        1'b0);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i),    bus.dec_pc,    vecs[i].e_pc);
        chk($sformatf("vec%0d_instr", i), bus.dec_instr, mem[vecs[i].e_pc[9:2]]);
      end
    end

    // EBREAK at 0x10 halts fetching but still reaches decode
    do_reset();
    mem[4] = EBREAK;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk1("brk_idle_en", bus.imem_en, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      chk1($sformatf("brk_en%0d", k),   bus.imem_en,   1'b1);
      chk ($sformatf("brk_addr%0d", k), bus.imem_addr, 32'(4 * k));
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk1("brk_halted",   halted,        1'b1);
    chk1("brk_en_off",   bus.imem_en,   1'b0);
    chk ("brk_pc_hold",  bus.imem_addr, 32'h10);
    chk1("brk_deliv_v",  bus.dec_valid, 1'b1);
    chk ("brk_deliv_pc", bus.dec_pc,    32'h10);
    chk ("brk_deliv_i",  bus.dec_instr, EBREAK);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk1("brk_drained",  bus.dec_valid, 1'b0);
    chk1("brk_en_off2",  bus.imem_en,   1'b0);
    chk ("brk_pc_hold2", bus.imem_addr, 32'h10);
    chk ("brk_fc",       fetch_count,   32'd5);
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    chk1("brk_redir_h",  halted,        1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk1("brk_resume_h", halted,        1'b0);
    chk1("brk_resume_e", bus.imem_en,   1'b1);
    chk ("brk_resume_a", bus.imem_addr, 32'h0);
    mem[4] = 32'h0000_0013 | (32'd4 << 20);

    // Asynchronous reset mid-run with a non-empty FIFO
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk1("arst_pre_valid", bus.dec_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("arst_valid", bus.dec_valid, 1'b0);
    chk ("arst_instr", bus.dec_instr, 32'h0);
    chk ("arst_pc",    bus.dec_pc,    32'h0);
    chk1("arst_en",    bus.imem_en,   1'b0);
    chk ("arst_addr",  bus.imem_addr, 32'h0);
    chk ("arst_fc",    fetch_count,   32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      chk1($sformatf("arst_idle_en%0d", k), bus.imem_en, 1'b0);
    end

    // Redirect during IDLE, then start
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 32'h23);
    chk1("idle_redir_en", bus.imem_en, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk1("idle_start_en", bus.imem_en,   1'b0);
    chk ("idle_pc",       bus.imem_addr, 32'h20);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk1("idle_first_en", bus.imem_en,   1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk1("idle_first_v",  bus.dec_valid, 1'b1);
    chk ("idle_first_pc", bus.dec_pc,    32'h20);

    // PC wrap at the top of the address space
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk ("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk ("wrap_pc",    bus.dec_pc,    32'hFFFF_FFFC);
    chk ("wrap_addr1", bus.imem_addr, 32'h0);

    // Randomized run against the queue model
    for (int i = 0; i < 256; i++) begin
      mem[i] = ($urandom_range(0, 15) == 0) ? EBREAK : ($urandom & 32'hFFFF_FF80) | 32'h13;
    end
    do_reset();
    m_mode = M_IDLE;
    m_pc   = 32'h0;
    m_fc   = 32'h0;
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      logic        st, rdy, rv, e_valid, e_pop, e_en, was_idle;
      logic [31:0] rpc, w;
      st  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 29) == 0);
      rpc = $urandom;
      drive(st, rdy, rv, rpc);
      e_valid = (mq.size() > 0);
      e_pop   = e_valid && rdy;
      e_en    = (m_mode == M_RUN) && !rv && ((mq.size() < QDEPTH) || e_pop);
      chk1("rnd_valid",  bus.dec_valid, e_valid);
      chk1("rnd_en",     bus.imem_en,   e_en);
      chk ("rnd_addr",   bus.imem_addr, m_pc);
      chk1("rnd_halted", halted,        m_mode == M_HALT);
      chk ("rnd_fc",     fetch_count,   m_fc);
      if (e_valid) begin
        chk("rnd_pc",    bus.dec_pc,    mq[0][63:32]);
        chk("rnd_instr", bus.dec_instr, mq[0][31:0]);
      end
      was_idle = (m_mode == M_IDLE);
      if (rv) begin
        mq.delete();
        m_pc = rpc & 32'hFFFF_FFFC;
        if (m_mode == M_HALT) m_mode = M_RUN;
      end else begin
        if (e_pop) begin
          void'(mq.pop_front());
          m_fc = m_fc + 1;
        end
        if (e_en) begin
          w = mem[m_pc[9:2]];
          mq.push_back({m_pc, w});
          if (w == EBREAK) m_mode = M_HALT;
          else m_pc = m_pc + 4;
        end
      end
      if (was_idle && st) m_mode = M_RUN;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
